seg_scan_driver: RTL and testbench
==================================

// Module: seg_scan_driver
// PURPOSE
//  Time-multiplexed driver for a bank of common-anode 7-segment digits.
//  Holds a frame of hex nibbles and scans one digit per slot, so one seg
//  bus serves every digit. Provides per-digit enable, decimal points,
//  leading-zero suppression, anti-ghost blanking and tear-free frame loads.
//  Sits between the datapath (nibble source) and the board seg/an pins.
// PARAMETERS
//  N_DIG     8       digits driven, 1..8
//  SCAN_DIV  100000  clk cycles per digit slot, >=2
//  BLANK     8       cycles at slot start with all an off, 0..SCAN_DIV-1
// PORTS
//  clk       in   1         system clock
//  rst       in   1         synchronous reset, active-high
//  data      in   4*N_DIG   nibbles; digit i = data[4i+3:4i], digit 0 = LSD
//  dp        in   N_DIG     decimal point request per digit, 1 = lit
//  dig_en    in   N_DIG     per-digit enable; 0 = digit dark in its slot
//  lz_sup    in   1         1 = suppress leading zeros
//  load      in   1         1-cycle strobe: capture data/dp/dig_en/lz_sup
//  seg       out  8         {dp,g..a}, active-low; 1 = segment off
//  an        out  N_DIG     digit select, active-low, at most one bit low
//  frame_tk  out  1         1-cycle pulse when scan wraps to digit 0
// BEHAVIOUR
//  Reset (sync, rst=1 at clk edge): seg=8'hFF, an=all 1, frame_tk=0,
//   div_cnt=0, idx=0, pending and shadow regs = 0 (all digits disabled).
//  div_cnt counts 0..SCAN_DIV-1 and wraps. On div_cnt==SCAN_DIV-1, idx
//   advances by 1; idx==N_DIG-1 wraps to 0 and frame_tk=1 that same edge.
//  load=1: pending <= {data,dp,dig_en,lz_sup}. Shadow <= pending only on
//   the idx wrap edge; displayed content changes only at frame boundaries.
//  load coincident with the wrap edge: shadow <= the new inputs directly,
//   bypassing pending; pending also takes the new inputs.
//  Outputs are registered, computed from the current idx/div_cnt/shadow;
//   seg/an reflect a new slot one cycle after idx changes.
//  an: an[idx]=0 when div_cnt>=BLANK and shadow dig_en[idx]=1 and digit
//   idx not suppressed; else all 1. seg=8'hFF whenever an is all 1.
//  seg[6:0] hex map (gfedcba, active-low): 0=40 1=79 2=24 3=30 4=19 5=12
//   6=02 7=78 8=00 9=18 A=08 b=03 C=46 d=21 E=06 F=0E. seg[7]=~dp[idx].
//  Leading-zero suppression (lz_sup=1): digit i is suppressed iff its
//   nibble and all nibbles at indices >i are 0. Digit 0 is never
//   suppressed (value 0 shows "0"). Disabled digits still count toward
//   the zero test by nibble value. A suppressed digit with dp=1 is NOT
//   suppressed (dp lit, seg[6:0]=7F).
//  Reset mid-slot/mid-frame: outputs blank on the next edge; scan restarts
//   at idx 0, div_cnt 0; previously loaded data is discarded.
//  Internal idx width = max(1,$clog2(N_DIG)); no illegal idx state exists.
// TESTING  (bench params N_DIG=4, SCAN_DIV=4, BLANK=1)
//  1 Reset: hold rst 3 cycles -> seg=FF, an=F, frame_tk=0 throughout; 1st
//    frame_tk exactly 16 cycles after rst release.
//  2 Scan: load data=16'h1A3F, dig_en=F, dp=0, lz_sup=0; after next wrap
//    -> per slot: 1 cycle an=F, then 3 cycles an=E/D/B/7 with
//    seg=8E/B0/88/F9.
//  3 Tear-free: load 16'h1234 mid-frame, then 16'h5678 before wrap -> old
//    frame finishes unchanged; next frame shows 5678 only.
//  4 LZ suppress: data=16'h0030, lz_sup=1, dp=0 -> digits 3,2 an stay F;
//    digit1 seg=B0, digit0 seg=C0. data=0 -> only digit0 lit, seg=C0.
//  5 dp/enable: dp=4'b0100, dig_en=4'b1011, data=16'h8888 -> digit2 an
//    stays F (disabled); digits 3,1,0 seg=80; dp seg[7]=1 on all lit.
//  6 Load on wrap edge + mid-frame reset: load pulse on frame_tk cycle ->
//    new data shown from digit 0 of that frame; rst mid-slot -> blank next
//    cycle, scan restarts at digit 0, all digits dark until next load.

Source files
------------

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment scanner with per-digit enable, decimal points,
// leading-zero suppression, anti-ghost blanking and frame-synchronous content updates.
module seg_scan_driver #(
  parameter int unsigned N_DIG    = 8,
  parameter int unsigned SCAN_DIV = 100000,
  parameter int unsigned BLANK    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4*N_DIG-1:0] data,
  input  logic [N_DIG-1:0]   dp,
  input  logic [N_DIG-1:0]   dig_en,
  input  logic               lz_sup,
  input  logic               load,
  output logic [7:0]         seg,
  output logic [N_DIG-1:0]   an,
  output logic               frame_tk
);

  localparam int unsigned IdxW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam int unsigned DivW = $clog2(SCAN_DIV);

  localparam logic [IdxW-1:0] IdxLast  = IdxW'(N_DIG - 1);
  localparam logic [DivW-1:0] DivLast  = DivW'(SCAN_DIV - 1);
  localparam logic [DivW-1:0] BlankCnt = DivW'(BLANK);

  if (N_DIG < 1 || N_DIG > 8) begin : gen_chk_ndig
    $error("seg_scan_driver: N_DIG must be in 1..8");
  end
  if (SCAN_DIV < 2) begin : gen_chk_div
    $error("seg_scan_driver: SCAN_DIV must be >= 2");
  end
  if (BLANK >= SCAN_DIV) begin : gen_chk_blank
    $error("seg_scan_driver: BLANK must be < SCAN_DIV");
  end

  typedef struct packed {
    logic [4*N_DIG-1:0] data;
    logic [N_DIG-1:0]   dp;
    logic [N_DIG-1:0]   en;
    logic               lz;
  } frame_t;

  // Active-low gfedcba pattern for one hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0: pat = 7'h40;
      4'h1: pat = 7'h79;
      4'h2: pat = 7'h24;
      4'h3: pat = 7'h30;
      4'h4: pat = 7'h19;
      4'h5: pat = 7'h12;
      4'h6: pat = 7'h02;
      4'h7: pat = 7'h78;
      4'h8: pat = 7'h00;
      4'h9: pat = 7'h18;
      4'hA: pat = 7'h08;
      4'hB: pat = 7'h03;
      4'hC: pat = 7'h46;
      4'hD: pat = 7'h21;
      4'hE: pat = 7'h06;
      4'hF: pat = 7'h0E;
      default: pat = 7'h7F;
    endcase
    return pat;
  endfunction

  logic [DivW-1:0]  div_cnt_q, div_cnt_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  frame_t           pend_q, pend_d;
  frame_t           shad_q, shad_d;
  logic [7:0]       seg_q, seg_d;
  logic [N_DIG-1:0] an_q, an_d;
  logic             frame_tk_q, frame_tk_d;

  frame_t           in_frame;
  logic             div_wrap;
  logic             frame_wrap;

  assign in_frame = '{data: data, dp: dp, en: dig_en, lz: lz_sup};

  // Scan counters and frame buffering.
  always_comb begin
    div_wrap   = (div_cnt_q == DivLast);
    frame_wrap = div_wrap && (idx_q == IdxLast);

    div_cnt_d = div_wrap ? '0 : div_cnt_q + 1'b1;

    idx_d = idx_q;
    if (div_wrap) begin
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
    end

    pend_d = load ? in_frame : pend_q;

    // A load landing on the wrap edge goes straight to the display so it is not lost a frame.
    shad_d = shad_q;
    if (frame_wrap) begin
      shad_d = load ? in_frame : pend_q;
    end

    frame_tk_d = frame_wrap;
  end

  logic [N_DIG-1:0] lz_hit;
  logic             zero_above;
  logic [3:0]       cur_nib;
  logic             cur_dp;
  logic             cur_en;
  logic             cur_lz;
  logic             lit;

  // Output decode for the slot currently addressed by idx_q.
  always_comb begin
    lz_hit     = '0;
    zero_above = 1'b1;
    for (int i = int'(N_DIG) - 1; i >= 0; i--) begin
      zero_above = zero_above && (shad_q.data[4*i +: 4] == 4'h0);
      lz_hit[i]  = zero_above && (i != 0) && shad_q.lz;
    end

    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    cur_en  = 1'b0;
    cur_lz  = 1'b0;
    for (int i = 0; i < int'(N_DIG); i++) begin
      if (idx_q == IdxW'(i)) begin
        cur_nib = shad_q.data[4*i +: 4];
        cur_dp  = shad_q.dp[i];
        cur_en  = shad_q.en[i];
        cur_lz  = lz_hit[i];
      end
    end

    // A suppressed zero still lights when its decimal point is requested.
    lit = (div_cnt_q >= BlankCnt) && cur_en && !(cur_lz && !cur_dp);

    an_d = '1;
    for (int i = 0; i < int'(N_DIG); i++) begin
      if (lit && (idx_q == IdxW'(i))) begin
        an_d[i] = 1'b0;
      end
    end

    seg_d = 8'hFF;
    if (lit) begin
      seg_d = {~cur_dp, cur_lz ? 7'h7F : hex7(cur_nib)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q  <= '0;
      idx_q      <= '0;
      pend_q     <= '0;
      shad_q     <= '0;
      seg_q      <= 8'hFF;
      an_q       <= '1;
      frame_tk_q <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      shad_q     <= shad_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
      frame_tk_q <= frame_tk_d;
    end
  end

  assign seg      = seg_q;
  assign an       = an_q;
  assign frame_tk = frame_tk_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed-vector bench for seg_scan_driver (4 digits, 4-cycle slots, 1-cycle blanking).
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data;
  logic [3:0]  dp;
  logic [3:0]  dig_en;
  logic        lz_sup;
  logic        load;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_tk;

  int checks   = 0;
  int failures = 0;

  seg_scan_driver #(
    .N_DIG   (4),
    .SCAN_DIV(4),
    .BLANK   (1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .data    (data),
    .dp      (dp),
    .dig_en  (dig_en),
    .lz_sup  (lz_sup),
    .load    (load),
    .seg     (seg),
    .an      (an),
    .frame_tk(frame_tk)
  );

  always #5 clk = ~clk;

  // an/seg hold the expected lit value per slot, slot 0 in the low bits.
  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  en;
    logic        lz;
    logic [15:0] an;
    logic [31:0] seg;
  } vec_t;

  vec_t vecs[8];
  vec_t dark;
  vec_t v1234;
  vec_t v5678;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_load(input vec_t v);
    data   = v.data;
    dp     = v.dp;
    dig_en = v.en;
    lz_sup = v.lz;
    load   = 1'b1;
  endtask

  task automatic do_load(input vec_t v);
    apply_load(v);
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_tk();
    int n = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end while (!frame_tk && n < 40);
    chk("wait_tk", {31'b0, frame_tk}, 32'd1);
  endtask

  // Starts at the negedge right after a wrap edge; checks all 16 cycles of the next frame.
  // Optional loads are issued after cycles lda/ldb (-1 = none).
  task automatic check_frame(input string tag, input vec_t v, input int lda, input vec_t va,
                             input int ldb, input vec_t vb);
    for (int k = 1; k <= 16; k++) begin
      int         s;
      int         c;
      logic [3:0] e_an;
      logic [7:0] e_seg;
      @(posedge clk);
      @(negedge clk);
      load  = 1'b0;
      s     = (k - 1) / 4;
      c     = (k - 1) % 4;
      e_an  = (c == 0) ? 4'hF : v.an[s*4 +: 4];
      e_seg = (e_an == 4'hF) ? 8'hFF : v.seg[s*8 +: 8];
      chk($sformatf("%s k=%0d {an,seg,tk}", tag, k), {19'b0, an, seg, frame_tk},
          {19'b0, e_an, e_seg, (k == 16)});
      if (k == lda) apply_load(va);
      if (k == ldb) apply_load(vb);
    end
  endtask

  initial begin
    //                data      dp    en    lz    an        seg
    vecs[0] = '{16'h1A3F, 4'h0, 4'hF, 1'b0, 16'h7BDE, 32'hF988B08E};
    vecs[1] = '{16'h0030, 4'h0, 4'hF, 1'b1, 16'hFFDE, 32'hFFFFB0C0};
    vecs[2] = '{16'h0000, 4'h0, 4'hF, 1'b1, 16'hFFFE, 32'hFFFFFFC0};
    vecs[3] = '{16'h8888, 4'h4, 4'hB, 1'b0, 16'h7FDE, 32'h80FF8080};
    vecs[4] = '{16'h0005, 4'h8, 4'hF, 1'b1, 16'h7FFE, 32'h7FFFFF92};
    vecs[5] = '{16'h1000, 4'h0, 4'h7, 1'b1, 16'hFBDE, 32'hFFC0C0C0};
    vecs[6] = '{16'hBD69, 4'h0, 4'hF, 1'b0, 16'h7BDE, 32'h83A18298};
    vecs[7] = '{16'h2CE4, 4'hF, 4'hF, 1'b0, 16'h7BDE, 32'h24460619};
    dark    = '{16'h0000, 4'h0, 4'h0, 1'b0, 16'hFFFF, 32'hFFFFFFFF};
    v1234   = '{16'h1234, 4'h0, 4'hF, 1'b0, 16'h7BDE, 32'hF9A4B099};
    v5678   = '{16'h5678, 4'h0, 4'hF, 1'b0, 16'h7BDE, 32'h9282F880};

    rst    = 1'b1;
    data   = '0;
    dp     = '0;
    dig_en = '0;
    lz_sup = 1'b0;
    load   = 1'b0;

    // Reset held three cycles: outputs blank, no tick.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("reset cyc%0d {an,seg,tk}", i), {19'b0, an, seg, frame_tk},
          {19'b0, 4'hF, 8'hFF, 1'b0});
    end
    rst = 1'b0;
    // First frame after reset is dark and ticks exactly on cycle 16.
    check_frame("post_reset", dark, -1, dark, -1, dark);

    for (int i = 0; i < 8; i++) begin
      do_load(vecs[i]);
      wait_tk();
      check_frame($sformatf("vec%0d", i), vecs[i], -1, dark, -1, dark);
    end

    // Two loads mid-frame: current frame untouched, only the last load shows next.
    check_frame("tear_old", vecs[7], 3, v1234, 9, v5678);
    check_frame("tear_new", v5678, -1, dark, -1, dark);

    // Load on the wrap edge is displayed in the very next frame.
    check_frame("wrapld_old", v5678, 15, vecs[0], -1, dark);
    check_frame("wrapld_new", vecs[0], -1, dark, -1, dark);

    // Mid-slot reset with a pending load outstanding.
    do_load(vecs[1]);
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst blank {an,seg,tk}", {19'b0, an, seg, frame_tk}, {19'b0, 4'hF, 8'hFF, 1'b0});
    check_frame("midrst_f1", dark, -1, dark, -1, dark);
    check_frame("midrst_f2", dark, -1, dark, -1, dark);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
